// File: rtl/cache_param_wb_if.sv
// CPU- and memory-side bus of the direct-mapped cache.
// The cache itself connects through the slave modport.
interface cache_param_wb_if #(
  parameter int ADDR_W         = 16,
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 4
);
  logic                             cpu_read;
  logic                             cpu_write;
  logic [ADDR_W-1:0]                cpu_addr;
  logic [WORD_W-1:0]                cpu_wdata;
  logic [WORD_W-1:0]                cpu_rdata;
  logic                             cpu_stall;
  logic                             flush;
  logic                             flush_busy;
  logic [ADDR_W-1:0]                mem_addr;
  logic                             mem_read;
  logic                             mem_write;
  logic [WORDS_PER_LINE-1:0]        mem_wmask;
  logic [WORD_W*WORDS_PER_LINE-1:0] mem_wdata;
  logic [WORD_W*WORDS_PER_LINE-1:0] mem_rdata;
  logic [15:0]                      hit_count;
  logic [15:0]                      miss_count;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, flush, mem_rdata,
    output cpu_rdata, cpu_stall, flush_busy, mem_addr, mem_read, mem_write,
           mem_wmask, mem_wdata, hit_count, miss_count
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, flush, mem_rdata,
    input  cpu_rdata, cpu_stall, flush_busy, mem_addr, mem_read, mem_write,
           mem_wmask, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/cache_param_wb.sv
// Direct-mapped cache with build-time write-through or write-back policy,
// fixed-latency line-wide memory port, dirty-line flush walk and hit/miss counters.
module cache_param_wb #(
  parameter int ADDR_W         = 16,
  parameter int WORD_W         = 16,
  parameter int NUM_LINES      = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_LATENCY    = 4,
  parameter int WRITE_BACK     = 0
) (
  input logic             clk,
  input logic             reset_n,
  cache_param_wb_if.slave bus
);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = ADDR_W - OW - IW;
  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, WB, FILL, WT, FLUSH} state_t;

  state_t state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  fidx;
  logic           done, retry;
  logic [15:0]    hit_cnt, miss_cnt;

  logic [NUM_LINES-1:0]                                 valid, dirty;
  logic [NUM_LINES-1:0][TW-1:0]                         tags;
  logic [NUM_LINES-1:0][WORDS_PER_LINE-1:0][WORD_W-1:0] data;

  logic [OW-1:0] off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          rd_req, wr_req, hit, last, victim_dirty;

  assign off          = bus.cpu_addr[OW-1:0];
  assign idx          = bus.cpu_addr[OW+IW-1:OW];
  assign tag          = bus.cpu_addr[ADDR_W-1:OW+IW];
  assign rd_req       = bus.cpu_read;
  assign wr_req       = bus.cpu_write & ~bus.cpu_read;  // read wins when both are raised
  assign hit          = valid[idx] && (tags[idx] == tag);
  assign last         = (cnt == CW'(MEM_LATENCY));
  assign victim_dirty = valid[idx] & dirty[idx];

  logic                             stall, mem_rd, mem_wr;
  logic [WORDS_PER_LINE-1:0]        wmask;
  logic [ADDR_W-1:0]                maddr;
  logic [WORD_W*WORDS_PER_LINE-1:0] mwdata;
  logic                             hit_inc, miss_inc, word_wr, fl_step;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    wmask     = '0;
    maddr     = {tag, idx, {OW{1'b0}}};
    mwdata    = data[idx];
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    word_wr   = 1'b0;
    fl_step   = 1'b0;
    unique case (state)
      IDLE: begin
        // done: the write-through request just finished, release it without a new transaction
        if (!done) begin
          if (rd_req || (wr_req && WRITE_BACK != 0)) begin
            if (hit) begin
              hit_inc = !retry;
              word_wr = wr_req;
            end else begin
              stall     = 1'b1;
              miss_inc  = 1'b1;
              state_nxt = victim_dirty ? WB : FILL;
            end
          end else if (wr_req) begin
            stall     = 1'b1;
            word_wr   = hit;
            hit_inc   = hit;
            miss_inc  = !hit;
            state_nxt = WT;
          end else if (bus.flush) begin
            state_nxt = FLUSH;
          end
        end
      end
      WB: begin
        stall  = 1'b1;
        mem_wr = 1'b1;
        wmask  = '1;
        maddr  = {tags[idx], idx, {OW{1'b0}}};
        if (last) state_nxt = FILL;
      end
      FILL: begin
        stall  = 1'b1;
        mem_rd = 1'b1;
        if (last) state_nxt = IDLE;
      end
      WT: begin
        stall  = 1'b1;
        mem_wr = 1'b1;
        wmask  = WORDS_PER_LINE'(1) << off;
        mwdata = {WORDS_PER_LINE{bus.cpu_wdata}};
        if (last) state_nxt = IDLE;
      end
      FLUSH: begin
        stall  = rd_req | bus.cpu_write;
        maddr  = {tags[fidx], fidx, {OW{1'b0}}};
        mwdata = data[fidx];
        if (valid[fidx] && dirty[fidx]) begin
          mem_wr  = 1'b1;
          wmask   = '1;
          fl_step = last;
        end else begin
          fl_step = 1'b1;
        end
        if (fl_step && fidx == IW'(NUM_LINES - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= CW'(1);
      fidx     <= '0;
      done     <= 1'b0;
      retry    <= 1'b0;
      valid    <= '0;
      dirty    <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= ((mem_rd || mem_wr) && !last) ? cnt + CW'(1) : CW'(1);
      done  <= (state == WT) && last;
      retry <= (state == FILL) && last;
      if (hit_inc && hit_cnt != 16'hFFFF)   hit_cnt  <= hit_cnt + 16'd1;
      if (miss_inc && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      if (word_wr && WRITE_BACK != 0) dirty[idx] <= 1'b1;
      if (state == WB && last) dirty[idx] <= 1'b0;
      if (state == FILL && last) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
      if (state == IDLE) fidx <= '0;
      if (state == FLUSH && fl_step) begin
        valid[fidx] <= 1'b0;
        dirty[fidx] <= 1'b0;
        fidx        <= fidx + IW'(1);
      end
    end
  end

  // Line storage is gated by reset so an abandoned fill never lands.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (word_wr) data[idx][off] <= bus.cpu_wdata;
      if (state == FILL && last) begin
        data[idx] <= bus.mem_rdata;
        tags[idx] <= tag;
      end
    end
  end

  assign bus.cpu_rdata  = data[idx][off];
  assign bus.cpu_stall  = stall;
  assign bus.flush_busy = (state == FLUSH);
  assign bus.mem_addr   = maddr;
  assign bus.mem_read   = mem_rd;
  assign bus.mem_write  = mem_wr;
  assign bus.mem_wmask  = wmask;
  assign bus.mem_wdata  = mwdata;
  assign bus.hit_count  = hit_cnt;
  assign bus.miss_count = miss_cnt;
endmodule
